// File: rtl/box_locator.sv
// Bounding box of flagged pixels in a raster-scanned mask, published once per
// frame as centre/size coordinates together with the flagged-pixel count.
module box_locator #(
   parameter int IMG_WIDTH  = 768,
   parameter int IMG_HEIGHT = 576,
   parameter int MIN_PIXELS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        hit,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic [9:0]  width,
   output logic [9:0]  height,
   output logic        found,
   output logic        frame_done,
   output logic [18:0] hit_count
);

   localparam logic [9:0]  COL_LAST = 10'(IMG_WIDTH - 1);
   localparam logic [9:0]  ROW_LAST = 10'(IMG_HEIGHT - 1);
   localparam logic [18:0] MIN_CNT  = 19'(MIN_PIXELS);

   localparam logic [0:0] SCAN    = 1'b0;
   localparam logic [0:0] PUBLISH = 1'b1;

   logic [0:0]  state;
   logic [9:0]  col, row;
   logic [9:0]  min_x, max_x, min_y, max_y;
   logic [18:0] cnt;
   logic [9:0]  nmin_x, nmax_x, nmin_y, nmax_y;
   logic [18:0] ncnt;
   logic [10:0] sum_x, sum_y;
   logic        last_pix;

   // Tracker values including the current pixel; the frame result uses these
   // so the final pixel's own hit is counted.
   always_comb begin
      nmin_x = min_x;
      nmax_x = max_x;
      nmin_y = min_y;
      nmax_y = max_y;
      ncnt   = cnt;
      if (wr_en && hit) begin
         ncnt = cnt + 19'd1;
         if (col < min_x) nmin_x = col;
         if (col > max_x) nmax_x = col;
         if (row < min_y) nmin_y = row;
         if (row > max_y) nmax_y = row;
      end
   end

   assign last_pix = wr_en && (col == COL_LAST) && (row == ROW_LAST);
   assign sum_x    = {1'b0, nmin_x} + {1'b0, nmax_x};
   assign sum_y    = {1'b0, nmin_y} + {1'b0, nmax_y};

   // PUBLISH lasts exactly one cycle; frame_done is a decode of that register.
   assign frame_done = (state == PUBLISH);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         col       <= '0;
         row       <= '0;
         min_x     <= COL_LAST;
         max_x     <= '0;
         min_y     <= ROW_LAST;
         max_y     <= '0;
         cnt       <= '0;
         x         <= '0;
         y         <= '0;
         width     <= '0;
         height    <= '0;
         found     <= 1'b0;
         hit_count <= '0;
      end else begin
         if (wr_en) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? 10'd0 : row + 10'd1;
            end else begin
               col <= col + 10'd1;
            end
         end

         if (last_pix) begin
            state     <= PUBLISH;
            hit_count <= ncnt;
            found     <= (ncnt >= MIN_CNT);
            if (ncnt >= MIN_CNT) begin
               x      <= sum_x[10:1];
               y      <= sum_y[10:1];
               width  <= nmax_x - nmin_x;
               height <= nmax_y - nmin_y;
            end
            // Reinitialise so a pixel accepted during PUBLISH starts a fresh frame.
            min_x <= COL_LAST;
            max_x <= '0;
            min_y <= ROW_LAST;
            max_y <= '0;
            cnt   <= '0;
         end else begin
            state <= SCAN;
            min_x <= nmin_x;
            max_x <= nmax_x;
            min_y <= nmin_y;
            max_y <= nmax_y;
            cnt   <= ncnt;
         end
      end
   end

endmodule

// File: tb/tb_box_locator.sv
// Directed bench for box_locator on a reduced 128x40 frame so that many frames
// fit in a short run; expected boxes are worked out by hand per stimulus mode.
module tb_box_locator;

   localparam int W    = 128;
   localparam int H    = 40;
   localparam int MINP = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic        hit;
   logic [9:0]  x, y, width, height;
   logic        found;
   logic        frame_done;
   logic [18:0] hit_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;
   int done_n = 0;
   int cap_n = 0;
   int cap_x[8], cap_y[8], cap_w[8], cap_h[8], cap_c[8], cap_f[8];
   int base;
   int done_before;

   box_locator #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(MINP)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .hit(hit),
      .x(x), .y(y), .width(width), .height(height),
      .found(found), .frame_done(frame_done), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (frame_done) done_n <= done_n + 1;
   end

   always @(negedge clk) begin
      if (frame_done && cap_n < 8) begin
         cap_x[cap_n] = int'(x);
         cap_y[cap_n] = int'(y);
         cap_w[cap_n] = int'(width);
         cap_h[cap_n] = int'(height);
         cap_c[cap_n] = int'(hit_count);
         cap_f[cap_n] = int'(found);
         cap_n = cap_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic is_hit(input int m, input int c, input int r);
      case (m)
         0: return c >= 100 && c <= 107 && r >= 20 && r <= 23;
         1: return (r == 0 && c < 63) || (c == W - 1 && r == H - 1);
         2: return r == 5 && c >= 10 && c <= 19;
         3: return c >= 10 && c <= 29 && r >= 30 && r <= 35;
         4: return c <= 3 && r <= 15;
         default: return 1'b0;
      endcase
   endfunction

   task automatic idle_cycle();
      @(negedge clk);
      wr_en = 1'b0;
      hit   = 1'($urandom_range(1));
   endtask

   // Streams one frame (or up to stop_row); wr_en is left high on the last pixel.
   task automatic send_frame(input int m, input int idle_pct, input int stop_row);
      for (int r = 0; r < H; r++) begin
         if (r == stop_row) return;
         for (int c = 0; c < W; c++) begin
            if (idle_pct > 0) begin
               while (int'($urandom_range(99)) < idle_pct) idle_cycle();
               if (c == W - 1 && r == H - 1) repeat (3) idle_cycle();
            end
            @(negedge clk);
            wr_en    = 1'b1;
            hit      = is_hit(m, c, r);
            last_cyc = cyc;
         end
      end
   endtask

   task automatic check_frame(input string t, input int ex, input int ey, input int ew,
                              input int eh, input int ef, input int ec);
      @(negedge clk);
      wr_en = 1'b0;
      hit   = 1'b0;
      chk({t, "_done"}, 32'(frame_done), 32'd1);
      chk({t, "_latency"}, 32'(cyc - last_cyc), 32'd1);
      chk({t, "_x"}, 32'(x), 32'(ex));
      chk({t, "_y"}, 32'(y), 32'(ey));
      chk({t, "_w"}, 32'(width), 32'(ew));
      chk({t, "_h"}, 32'(height), 32'(eh));
      chk({t, "_found"}, 32'(found), 32'(ef));
      chk({t, "_count"}, 32'(hit_count), 32'(ec));
      @(negedge clk);
      chk({t, "_pulse_end"}, 32'(frame_done), 32'd0);
   endtask

   task automatic check_zero(input string t);
      chk({t, "_x"}, 32'(x), 32'd0);
      chk({t, "_y"}, 32'(y), 32'd0);
      chk({t, "_w"}, 32'(width), 32'd0);
      chk({t, "_h"}, 32'(height), 32'd0);
      chk({t, "_found"}, 32'(found), 32'd0);
      chk({t, "_done"}, 32'(frame_done), 32'd0);
      chk({t, "_count"}, 32'(hit_count), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      hit   = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      // rectangle cols 100..107 rows 20..23
      send_frame(0, 0, -1);
      check_frame("rect", 103, 21, 7, 3, 1, 32);

      // 10 flagged pixels: below threshold, box holds
      send_frame(2, 0, -1);
      check_frame("sparse", 103, 21, 7, 3, 0, 10);

      // last pixel of the frame is itself flagged
      send_frame(1, 0, -1);
      check_frame("corner", 63, 19, 127, 39, 1, 64);

      // same rectangle with ~30% idle cycles and a stall before the final pixel
      send_frame(0, 30, -1);
      check_frame("gaps", 103, 21, 7, 3, 1, 32);

      // abort mid-frame (hits already seen in rows 30..31), then a clean frame
      done_before = done_n;
      send_frame(3, 0, 32);
      @(negedge clk);
      wr_en = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("midreset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_no_done", 32'(done_n), 32'(done_before));
      send_frame(0, 0, -1);
      check_frame("clean", 103, 21, 7, 3, 1, 32);

      // back-to-back frames, wr_en high through PUBLISH
      base = cap_n;
      send_frame(3, 0, -1);
      send_frame(4, 0, -1);
      check_frame("b2b_b", 1, 7, 3, 15, 1, 64);
      chk("b2b_caps", 32'(cap_n - base), 32'd2);
      if (cap_n - base >= 1) begin
         chk("b2b_a_x", 32'(cap_x[base]), 32'd19);
         chk("b2b_a_y", 32'(cap_y[base]), 32'd32);
         chk("b2b_a_w", 32'(cap_w[base]), 32'd19);
         chk("b2b_a_h", 32'(cap_h[base]), 32'd5);
         chk("b2b_a_count", 32'(cap_c[base]), 32'd120);
         chk("b2b_a_found", 32'(cap_f[base]), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
